// File: rtl/dog_pkg.sv
// dog_pkg: frame codes, default sprite geometry and renderer state shared
// by the dog controller and the dog sprite renderer.
package dog_pkg;
    localparam logic [4:0] FR_SIT       = 5'd0;
    localparam logic [4:0] FR_WALK1     = 5'd1;
    localparam logic [4:0] FR_WALK2     = 5'd2;
    localparam logic [4:0] FR_WALK3     = 5'd3;
    localparam logic [4:0] FR_SNIFF1    = 5'd4;
    localparam logic [4:0] FR_SNIFF2    = 5'd5;
    localparam logic [4:0] FR_SURPRISED = 5'd6;
    localparam logic [4:0] FR_JUMP1     = 5'd7;
    localparam logic [4:0] FR_JUMP2     = 5'd8;
    localparam logic [4:0] FR_HIDDEN    = 5'd31;

    localparam int DOG_W = 56;
    localparam int DOG_H = 48;

    typedef enum logic [1:0] {NOSPRITE, SHOW, HIDE} rend_state_e;
endpackage

// File: rtl/sprite_box_test.sv
// sprite_box_test: tests whether a scan pixel lies inside a W x H sprite box
// anchored at (s_x_i, s_y_i) and returns the in-box offsets.
module sprite_box_test #(
    parameter int W     = 56,
    parameter int H     = 48,
    parameter int OFS_W = 6
) (
    input  logic [9:0]       draw_x_i,
    input  logic [9:0]       draw_y_i,
    input  logic [9:0]       s_x_i,
    input  logic [9:0]       s_y_i,
    output logic             in_box_o,
    output logic [OFS_W-1:0] rx_o,
    output logic [OFS_W-1:0] ry_o
);
    logic [10:0] dx, dy;
    logic        ge_x, ge_y;

    assign ge_x = draw_x_i >= s_x_i;
    assign ge_y = draw_y_i >= s_y_i;
    // 11-bit differences: right/bottom edges past 1023 never wrap back on screen
    assign dx = {1'b0, draw_x_i} - {1'b0, s_x_i};
    assign dy = {1'b0, draw_y_i} - {1'b0, s_y_i};

    assign in_box_o = ge_x && ge_y && dx < 11'(W) && dy < 11'(H);
    assign rx_o     = ge_x ? dx[OFS_W-1:0] : '0;
    assign ry_o     = ge_y ? dy[OFS_W-1:0] : '0;
endmodule

// File: rtl/dog_sprite_renderer.sv
// dog_sprite_renderer: per-frame snapshot of the dog pose plus a fixed 3-cycle
// pixel pipeline that looks the sprite up in a synchronous palette-index ROM.
module dog_sprite_renderer
    import dog_pkg::*;
#(
    parameter int         SPRITE_W        = DOG_W,
    parameter int         SPRITE_H        = DOG_H,
    parameter int         NUM_FRAMES      = 9,
    parameter int         ADDR_W          = 15,
    parameter logic [3:0] TRANSPARENT_IDX = 4'h0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Frame_start,
    input  logic [9:0]        Dog_X,
    input  logic [9:0]        Dog_Y,
    input  logic [4:0]        Frame,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              Pix_valid,
    output logic [ADDR_W-1:0] Rom_addr,
    input  logic [3:0]        Rom_data,
    output logic [3:0]        Dog_pixel,
    output logic              Dog_hit,
    output logic              Out_valid,
    output logic              Sprite_visible
);
    localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPRITE_W * SPRITE_H);
    localparam logic [ADDR_W-1:0] ROW_SZ   = ADDR_W'(SPRITE_W);

    rend_state_e       state_q, state_d;
    logic [9:0]        sx_q, sy_q;
    logic [4:0]        sf_q, f1_q;
    logic [5:0]        rx1_q, ry1_q, rx, ry;
    logic              v1_q, in1_q, v2_q, in2_q, v3_q, in3_q, in_box;
    logic [ADDR_W-1:0] addr_d;

    sprite_box_test #(.W(SPRITE_W), .H(SPRITE_H), .OFS_W(6)) u_box (
        .draw_x_i (DrawX),
        .draw_y_i (DrawY),
        .s_x_i    (sx_q),
        .s_y_i    (sy_q),
        .in_box_o (in_box),
        .rx_o     (rx),
        .ry_o     (ry)
    );

    always_comb begin
        state_d = Frame_start ? ((32'(Frame) < NUM_FRAMES) ? SHOW : HIDE) : state_q;
        addr_d  = (v1_q && in1_q)
                ? ADDR_W'(f1_q) * FRAME_SZ + ADDR_W'(ry1_q) * ROW_SZ + ADDR_W'(rx1_q)
                : Rom_addr;
    end

    assign Sprite_visible = state_q == SHOW;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= NOSPRITE;
            sx_q      <= '0;
            sy_q      <= '0;
            sf_q      <= '0;
            v1_q      <= 1'b0;
            in1_q     <= 1'b0;
            rx1_q     <= '0;
            ry1_q     <= '0;
            f1_q      <= '0;
            v2_q      <= 1'b0;
            in2_q     <= 1'b0;
            v3_q      <= 1'b0;
            in3_q     <= 1'b0;
            Rom_addr  <= '0;
            Out_valid <= 1'b0;
            Dog_pixel <= '0;
            Dog_hit   <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (Frame_start) begin
                sx_q <= Dog_X;
                sy_q <= Dog_Y;
                sf_q <= Frame;
            end
            v1_q      <= Pix_valid;
            in1_q     <= in_box;
            rx1_q     <= rx;
            ry1_q     <= ry;
            f1_q      <= sf_q;
            Rom_addr  <= addr_d;
            v2_q      <= v1_q;
            // gating with v1 keeps Dog_hit low in blank slots even over the box
            in2_q     <= v1_q && in1_q && state_q == SHOW;
            v3_q      <= v2_q;
            in3_q     <= in2_q;
            Out_valid <= v3_q;
            Dog_pixel <= in3_q ? Rom_data : TRANSPARENT_IDX;
            Dog_hit   <= in3_q && Rom_data != TRANSPARENT_IDX;
        end
    end
endmodule

// File: doc/dog_sprite_renderer.md
Name: dog_sprite_renderer

Overview:
- Consumer end of the dog controller's Dog_X / Dog_Y / Frame interface.
- Snapshots the dog position and animation frame once per video frame, at the start of vertical blank.
- For every pixel the VGA timing block scans out, tests whether the pixel falls inside the dog sprite box and fetches the matching palette index from the synchronous sprite ROM.
- Feeds the colour mapper through a fixed 3-cycle pipeline.

Parameters:
- SPRITE_W, 56: sprite width in pixels.
- SPRITE_H, 48: sprite height in pixels.
- NUM_FRAMES, 9: frames stored in ROM (codes 0..8); Frame codes at or above this value hide the dog.
- ADDR_W, 15: ROM address width; must satisfy NUM_FRAMES*SPRITE_W*SPRITE_H <= 2**ADDR_W.
- TRANSPARENT_IDX, 4'h0: palette index treated as background.

Ports:
- Clk, in, 1: pixel/system clock.
- Reset_n, in, 1: one clock; reset is asynchronous and active-low.
- Frame_start, in, 1: one-cycle pulse at start of vertical blank.
- Dog_X, in, 10: sprite left edge, screen x.
- Dog_Y, in, 10: sprite top edge, screen y.
- Frame, in, 5: animation frame code.
- DrawX, in, 10: current scan x.
- DrawY, in, 10: current scan y.
- Pix_valid, in, 1: high during the active video region.
- Rom_addr, out, ADDR_W: registered sprite ROM address.
- Rom_data, in, 4: ROM palette index; valid one cycle after Rom_addr.
- Dog_pixel, out, 4: palette index for the pixel.
- Dog_hit, out, 1: pixel belongs to the dog and is opaque.
- Out_valid, out, 1: Dog_pixel/Dog_hit correspond to a valid scan pixel.
- Sprite_visible, out, 1: latched visibility for the current video frame.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - All outputs 0, Rom_addr 0.
  - Shadow registers cleared; pipeline valids cleared.
  - State NOSPRITE.
  - Reset deasserted mid-line: no stale pixel is ever emitted; Out_valid stays 0 until 3 cycles after the first sampled Pix_valid=1.
- State machine, updated only on Frame_start:
  - NOSPRITE: initial state; Dog_hit forced 0.
  - Frame_start with Frame < NUM_FRAMES → SHOW; otherwise → HIDE.
  - SHOW and HIDE re-evaluate on every Frame_start using the same rule.
  - Sprite_visible = (state == SHOW).
- Snapshot: on Frame_start, sX <= Dog_X, sY <= Dog_Y, sF <= Frame. Shadow values stay constant for the whole video frame; mid-frame changes on the Dog_* inputs are ignored.
- Simultaneous events:
  - Frame_start and Pix_valid sampled in the same cycle: that pixel uses the old snapshot.
  - Pixels already inside the pipeline always complete with the snapshot they entered with.
- Pipeline stage 1 (edge k):
  - v1 <= Pix_valid.
  - in1 <= DrawX >= sX && DrawX < sX+SPRITE_W && DrawY >= sY && DrawY < sY+SPRITE_H.
  - Comparisons use 11-bit unsigned arithmetic, so no wrap at the screen edge.
  - Subtraction is never taken when DrawX < sX.
  - rx1 <= DrawX-sX and ry1 <= DrawY-sY, truncated to 6 bits; meaningful only when in1=1.
  - f1 <= sF.
- Pipeline stage 2 (edge k+1):
  - Rom_addr <= f1*SPRITE_W*SPRITE_H + ry1*SPRITE_W + rx1 when v1&&in1; otherwise Rom_addr holds its previous value.
  - v2 <= v1; in2 <= in1 && state==SHOW.
- Stage 3 (edge k+3; ROM returns Rom_data during cycle k+2):
  - Out_valid <= v3.
  - Dog_pixel <= in3 ? Rom_data : TRANSPARENT_IDX.
  - Dog_hit <= in3 && Rom_data != TRANSPARENT_IDX.
  - v3/in3 are delay registers aligned to the ROM latency.
- Latency: exactly 3 cycles from DrawX/DrawY/Pix_valid sampling to outputs. Throughput: 1 pixel per clock with no stalls.
- Pix_valid=0: Out_valid=0, Dog_hit=0 for that slot.

Decomposition:
- Shared package dog_pkg holds:
  - Frame code constants (FR_SIT=0, FR_WALK1..3=1..3, FR_SNIFF1/2=4/5, FR_SURPRISED=6, FR_JUMP1/2=7/8, FR_HIDDEN=31).
  - SPRITE_W/SPRITE_H defaults.
  - The renderer state enum {NOSPRITE, SHOW, HIDE}.
- The dog controller imports the same frame constants.
- One sub-module, sprite_box_test: the stage-1 inclusion compare and offset subtraction. It is reused later for duck sprites.

Test Plan:
- Reset, then pixels with no Frame_start: DrawX=11, DrawY=318 with Pix_valid=1 → Out_valid=1 after 3 cycles, Dog_hit=0, Sprite_visible=0.
- Snapshot (11,318), Frame=0, then DrawX=11, DrawY=318 → Rom_addr=0 after edge k+1; ROM returns 4'h5 → Dog_pixel=5, Dog_hit=1 at k+3.
- Frame=1, position (11,318); DrawX=12, DrawY=319 → Rom_addr=2745. DrawX=67 (sX+56) → Dog_hit=0 and Rom_addr unchanged.
- Dog_X=620, DrawX=639: in box, rx=19. Dog_X=620, DrawX=5: not in box, no wrap. Frame=8 corner (55,47) → Rom_addr=24191.
- Dog_X changed mid-frame to 200 without Frame_start → hits still at x=11..66. Frame=31 latched → Sprite_visible=0, Dog_hit=0 everywhere.
- Reset_n pulsed low for 1 cycle mid-line with valid pixels in flight → Out_valid, Dog_hit and Rom_addr read 0 immediately. Out_valid returns 3 cycles after the next Pix_valid.
